wired_commit_lsu_seq: RTL and testbench

Sequences all commit-time memory side effects that the commit FSM issues from slot 0: uncached load, uncached store, cache-missed store and store-conditional. It accepts one command at a time from the commit FSM and drives the LSU commit request/response channel. It handles refill-and-retry for missed stores and applies the link-bit check for SC. It returns a single completion pulse carrying load data, the SC result, a flush demand and an error flag.

---
 rtl/wired_commit_lsu_seq_if.sv | 31 +++
 rtl/wired_commit_lsu_seq.sv | 215 +++++++++++++++++++++
 tb/tb_wired_commit_lsu_seq.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wired_commit_lsu_seq_if.sv
// rtl/wired_commit_lsu_seq_if.sv - LSU commit request/response channel
// Purpose: bundles the single-outstanding LSU commit request and its response.
// Signals:
//   req_valid/req_ready   request handshake (sequencer -> LSU)
//   req_op                0 READ_U, 1 WRITE_U, 2 REFILL, 3 WRITE_C
//   req_addr/wdata/strb   request payload
//   resp_valid            response strobe (LSU -> sequencer)
//   resp_rdata            read data for READ_U
//   resp_hit              WRITE_C: line present and write performed
// Modports: master = sequencer side, slave = LSU side.
interface wired_commit_lsu_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_strb;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_hit;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, req_strb,
    input  req_ready, resp_valid, resp_rdata, resp_hit
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, req_strb,
    output req_ready, resp_valid, resp_rdata, resp_hit
  );
endinterface

// File: rtl/wired_commit_lsu_seq.sv
// rtl/wired_commit_lsu_seq.sv - commit-time memory side-effect sequencer
// Purpose: takes one ULOAD/USTORE/MSTORE/SC command at a time from the commit
// FSM, drives the LSU commit channel (with refill-and-retry for missed stores
// and the link-bit check for SC), and returns a one-cycle completion pulse.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   cmd_valid_i/cmd_ready_o  command handshake (ready only when idle)
//   cmd_op_i                 0 ULOAD, 1 USTORE, 2 MSTORE, 3 SC
//   cmd_addr_i/wdata_i/strb_i command payload, latched at acceptance
//   llbit_i                  LL link bit, sampled at acceptance
//   done_o                   completion pulse
//   done_rdata_o/sc_ok_o/flush_o/err_o  completion payload (0 unless done_o)
//   lsu                      LSU request/response channel (master side)
module wired_commit_lsu_seq #(
  parameter int MAX_REFILL = 2,
  parameter int TIMEOUT    = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [1:0]  cmd_op_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  input  logic [3:0]  cmd_strb_i,
  input  logic        llbit_i,
  output logic        done_o,
  output logic [31:0] done_rdata_o,
  output logic        done_sc_ok_o,
  output logic        done_flush_o,
  output logic        done_err_o,
  wired_commit_lsu_seq_if.master lsu
);

  localparam logic [1:0] OP_ULOAD  = 2'd0;
  localparam logic [1:0] OP_USTORE = 2'd1;
  localparam logic [1:0] OP_MSTORE = 2'd2;
  localparam logic [1:0] OP_SC     = 2'd3;

  localparam logic [1:0] LSU_READ_U  = 2'd0;
  localparam logic [1:0] LSU_WRITE_U = 2'd1;
  localparam logic [1:0] LSU_REFILL  = 2'd2;
  localparam logic [1:0] LSU_WRITE_C = 2'd3;

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam int RC_W = $clog2(MAX_REFILL + 2);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_REFILL_REQ, S_REFILL_WAIT, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      strb_q, strb_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            sc_ok_q, sc_ok_d;
  logic            flush_q, flush_d;
  logic            err_q, err_d;
  logic [RC_W-1:0] refill_cnt_q, refill_cnt_d;
  logic [WD_W-1:0] wdog_q, wdog_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      strb_q       <= '0;
      rdata_q      <= '0;
      sc_ok_q      <= 1'b0;
      flush_q      <= 1'b0;
      err_q        <= 1'b0;
      refill_cnt_q <= '0;
      wdog_q       <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      strb_q       <= strb_d;
      rdata_q      <= rdata_d;
      sc_ok_q      <= sc_ok_d;
      flush_q      <= flush_d;
      err_q        <= err_d;
      refill_cnt_q <= refill_cnt_d;
      wdog_q       <= wdog_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    strb_d        = strb_q;
    rdata_d       = rdata_q;
    sc_ok_d       = sc_ok_q;
    flush_d       = flush_q;
    err_d         = err_q;
    refill_cnt_d  = refill_cnt_q;
    wdog_d        = wdog_q;
    lsu.req_valid = 1'b0;
    lsu.req_op    = LSU_READ_U;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          op_d         = cmd_op_i;
          addr_d       = cmd_addr_i;
          wdata_d      = cmd_wdata_i;
          strb_d       = cmd_strb_i;
          refill_cnt_d = '0;
          rdata_d      = '0;
          sc_ok_d      = 1'b0;
          flush_d      = 1'b0;
          err_d        = 1'b0;
          // A lost link fails the SC without touching memory.
          if (cmd_op_i == OP_SC && !llbit_i) begin
            flush_d = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_REQ;
          end
        end
      end

      S_REQ: begin
        lsu.req_valid = 1'b1;
        case (op_q)
          OP_ULOAD:  lsu.req_op = LSU_READ_U;
          OP_USTORE: lsu.req_op = LSU_WRITE_U;
          default:   lsu.req_op = LSU_WRITE_C;
        endcase
        // Any response seen here is stale: the LSU never answers in the
        // acceptance cycle, so only the handshake matters.
        if (lsu.req_ready) begin
          state_d = S_WAIT;
          wdog_d  = '0;
        end
      end

      S_WAIT: begin
        if (lsu.resp_valid) begin
          state_d = S_DONE;
          case (op_q)
            OP_ULOAD: begin
              rdata_d = lsu.resp_rdata;
              flush_d = 1'b1;
            end
            OP_USTORE: flush_d = 1'b1;
            OP_MSTORE: begin
              if (!lsu.resp_hit) begin
                if (refill_cnt_q < RC_W'(MAX_REFILL)) begin
                  state_d = S_REFILL_REQ;
                end else begin
                  err_d   = 1'b1;
                  flush_d = 1'b1;
                end
              end
            end
            default: begin
              sc_ok_d = lsu.resp_hit;
              flush_d = !lsu.resp_hit;
            end
          endcase
        end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          flush_d = 1'b1;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end

      S_REFILL_REQ: begin
        lsu.req_valid = 1'b1;
        lsu.req_op    = LSU_REFILL;
        if (lsu.req_ready) begin
          refill_cnt_d = refill_cnt_q + 1'b1;
          state_d      = S_REFILL_WAIT;
          wdog_d       = '0;
        end
      end

      S_REFILL_WAIT: begin
        if (lsu.resp_valid) begin
          state_d = S_REQ;
        end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          flush_d = 1'b1;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign lsu.req_addr  = lsu.req_valid ? addr_q  : '0;
  assign lsu.req_wdata = lsu.req_valid ? wdata_q : '0;
  assign lsu.req_strb  = lsu.req_valid ? strb_q  : '0;

  assign cmd_ready_o  = (state_q == S_IDLE);
  assign done_o       = (state_q == S_DONE);
  assign done_rdata_o = done_o ? rdata_q : '0;
  assign done_sc_ok_o = done_o & sc_ok_q;
  assign done_flush_o = done_o & flush_q;
  assign done_err_o   = done_o & err_q;

endmodule

// File: tb/tb_wired_commit_lsu_seq.sv
// tb/tb_wired_commit_lsu_seq.sv - directed bench for wired_commit_lsu_seq
module tb_wired_commit_lsu_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        llbit;
  logic        done;
  logic [31:0] done_rdata;
  logic        done_sc_ok;
  logic        done_flush;
  logic        done_err;

  wired_commit_lsu_seq_if lsu_if ();

  wired_commit_lsu_seq #(.MAX_REFILL(2), .TIMEOUT(1024)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_op_i     (cmd_op),
    .cmd_addr_i   (cmd_addr),
    .cmd_wdata_i  (cmd_wdata),
    .cmd_strb_i   (cmd_strb),
    .llbit_i      (llbit),
    .done_o       (done),
    .done_rdata_o (done_rdata),
    .done_sc_ok_o (done_sc_ok),
    .done_flush_o (done_flush),
    .done_err_o   (done_err),
    .lsu          (lsu_if.master)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_reqcyc = 0;
  int n_wc = 0;
  int n_refill = 0;
  int n_refill_badaddr = 0;

  logic [31:0] cur_addr, cur_wdata;
  logic [3:0]  cur_strb;

  always @(posedge clk) begin
    if (!rst) begin
      if (lsu_if.req_valid) n_reqcyc <= n_reqcyc + 1;
      if (lsu_if.req_valid && lsu_if.req_ready) begin
        if (lsu_if.req_op == 2'd3) n_wc <= n_wc + 1;
        if (lsu_if.req_op == 2'd2) begin
          n_refill <= n_refill + 1;
          if (lsu_if.req_addr !== cur_addr) n_refill_badaddr <= n_refill_badaddr + 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command in the current (idle) cycle; returns in cycle T+1.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] sb, input logic ll);
    cur_addr = a; cur_wdata = wd; cur_strb = sb;
    chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_wdata = wd; cmd_strb = sb; llbit = ll;
    tick();
    cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0; llbit = 1'b0;
  endtask

  // Called in a request-state cycle: handshake, wait gap cycles, respond once.
  task automatic lsu_xact(input string tag, input logic [1:0] exp_op, input int gap,
                          input logic hit, input logic [31:0] rd);
    chk({tag, "_valid"}, {31'd0, lsu_if.req_valid}, 32'd1);
    chk({tag, "_op"}, {30'd0, lsu_if.req_op}, {30'd0, exp_op});
    chk({tag, "_addr"}, lsu_if.req_addr, cur_addr);
    lsu_if.req_ready = 1'b1;
    tick();
    lsu_if.req_ready = 1'b0;
    repeat (gap) tick();
    chk({tag, "_nodone_wait"}, {31'd0, done}, 32'd0);
    lsu_if.resp_valid = 1'b1; lsu_if.resp_hit = hit; lsu_if.resp_rdata = rd;
    tick();
    lsu_if.resp_valid = 1'b0; lsu_if.resp_hit = 1'b0; lsu_if.resp_rdata = '0;
  endtask

  task automatic chk_done(input string tag, input logic [31:0] rd, input logic ok,
                          input logic fl, input logic er);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_rdata"}, done_rdata, rd);
    chk({tag, "_sc_ok"}, {31'd0, done_sc_ok}, {31'd0, ok});
    chk({tag, "_flush"}, {31'd0, done_flush}, {31'd0, fl});
    chk({tag, "_err"}, {31'd0, done_err}, {31'd0, er});
    tick();
    chk({tag, "_payload_clear"}, {done_rdata[31:1], done_rdata[0] | done | done_sc_ok | done_flush | done_err}, 32'd0);
    chk({tag, "_ready_after"}, {31'd0, cmd_ready}, 32'd1);
  endtask

  int base_wc, base_rf, base_rq, bad;

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0; llbit = 1'b0;
    lsu_if.req_ready = 1'b0; lsu_if.resp_valid = 1'b0; lsu_if.resp_rdata = '0; lsu_if.resp_hit = 1'b0;
    cur_addr = '0; cur_wdata = '0; cur_strb = '0;
    tick(); tick();

    // Reset state
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_req_valid", {31'd0, lsu_if.req_valid}, 32'd0);
    chk("rst_outputs_zero", done_rdata | lsu_if.req_addr | lsu_if.req_wdata |
        {28'd0, lsu_if.req_strb} | {30'd0, lsu_if.req_op} |
        {29'd0, done_sc_ok, done_flush, done_err}, 32'd0);
    rst = 1'b0;
    tick();

    // ULOAD: ready at T+1, response at T+4, done at T+5
    issue(2'd0, 32'h1FE0_0000, 32'h0, 4'hF, 1'b0);
    lsu_xact("uload", 2'd0, 2, 1'b0, 32'hDEADBEEF);
    chk_done("uload", 32'hDEADBEEF, 1'b0, 1'b1, 1'b0);

    // MSTORE: miss, one refill, then hit
    base_wc = n_wc; base_rf = n_refill;
    issue(2'd2, 32'h0000_1040, 32'hCAFE_F00D, 4'h3, 1'b0);
    lsu_xact("ms1_wc0", 2'd3, 0, 1'b0, 32'h0);
    lsu_xact("ms1_rf0", 2'd2, 1, 1'b0, 32'h0);
    lsu_xact("ms1_wc1", 2'd3, 0, 1'b1, 32'h0);
    chk_done("ms1", 32'h0, 1'b0, 1'b0, 1'b0);
    chk("ms1_refills", n_refill - base_rf, 32'd1);
    chk("ms1_writec", n_wc - base_wc, 32'd2);

    // MSTORE: every WRITE_C misses -> 3 WRITE_C, 2 REFILL, err
    base_wc = n_wc; base_rf = n_refill;
    issue(2'd2, 32'h0000_2080, 32'h1234_5678, 4'hC, 1'b0);
    lsu_xact("ms2_wc0", 2'd3, 0, 1'b0, 32'h0);
    lsu_xact("ms2_rf0", 2'd2, 0, 1'b0, 32'h0);
    lsu_xact("ms2_wc1", 2'd3, 0, 1'b0, 32'h0);
    lsu_xact("ms2_rf1", 2'd2, 0, 1'b0, 32'h0);
    lsu_xact("ms2_wc2", 2'd3, 0, 1'b0, 32'h0);
    chk_done("ms2", 32'h0, 1'b0, 1'b1, 1'b1);
    chk("ms2_refills", n_refill - base_rf, 32'd2);
    chk("ms2_writec", n_wc - base_wc, 32'd3);
    chk("refill_addr_same", n_refill_badaddr, 32'd0);

    // SC with lost link: no LSU traffic, done at T+1
    base_rq = n_reqcyc;
    issue(2'd3, 32'h0000_3000, 32'h1, 4'hF, 1'b0);
    chk("sc0_req_valid", {31'd0, lsu_if.req_valid}, 32'd0);
    chk_done("sc0", 32'h0, 1'b0, 1'b1, 1'b0);
    chk("sc0_no_lsu", n_reqcyc - base_rq, 32'd0);

    // SC with link, hit -> success
    issue(2'd3, 32'h0000_3004, 32'h2, 4'hF, 1'b1);
    lsu_xact("sc1", 2'd3, 1, 1'b1, 32'h0);
    chk_done("sc1", 32'h0, 1'b1, 1'b0, 1'b0);

    // SC with link, miss -> fail, no refill
    base_rf = n_refill;
    issue(2'd3, 32'h0000_3008, 32'h3, 4'hF, 1'b1);
    lsu_xact("sc2", 2'd3, 0, 1'b0, 32'h0);
    chk_done("sc2", 32'h0, 1'b0, 1'b1, 1'b0);
    chk("sc2_no_refill", n_refill - base_rf, 32'd0);

    // USTORE: response coinciding with request acceptance is ignored
    issue(2'd1, 32'h0000_4000, 32'hA5A5_5A5A, 4'h1, 1'b0);
    lsu_if.req_ready = 1'b1; lsu_if.resp_valid = 1'b1;
    tick();
    lsu_if.req_ready = 1'b0; lsu_if.resp_valid = 1'b0;
    chk("us_simul_nodone", {31'd0, done}, 32'd0);
    tick();
    chk("us_simul_still_wait", {31'd0, done}, 32'd0);
    lsu_if.resp_valid = 1'b1;
    tick();
    lsu_if.resp_valid = 1'b0;
    chk_done("us_simul", 32'h0, 1'b0, 1'b1, 1'b0);

    // USTORE stalled 5 cycles, then no response -> timeout
    issue(2'd1, 32'h0000_5554, 32'h0BAD_F00D, 4'h6, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", {31'd0, lsu_if.req_valid}, 32'd1);
      chk("stall_op", {30'd0, lsu_if.req_op}, 32'd1);
      chk("stall_addr", lsu_if.req_addr, 32'h0000_5554);
      chk("stall_wdata", lsu_if.req_wdata, 32'h0BAD_F00D);
      chk("stall_strb", {28'd0, lsu_if.req_strb}, 32'h6);
      tick();
    end
    lsu_if.req_ready = 1'b1;
    tick();
    lsu_if.req_ready = 1'b0;
    bad = 0;
    for (int i = 0; i < 1024; i++) begin
      if (done || lsu_if.req_valid) bad++;
      tick();
    end
    chk("to_quiet_wait", bad, 32'd0);
    chk("to_req_valid", {31'd0, lsu_if.req_valid}, 32'd0);
    chk_done("timeout", 32'h0, 1'b0, 1'b1, 1'b1);

    // Reset in S_WAIT, late response ignored, fresh ULOAD completes
    issue(2'd0, 32'h1FE0_0010, 32'h0, 4'hF, 1'b0);
    lsu_if.req_ready = 1'b1;
    tick();
    lsu_if.req_ready = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("rstmid_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rstmid_done", {31'd0, done}, 32'd0);
    tick();
    rst = 1'b0;
    lsu_if.resp_valid = 1'b1; lsu_if.resp_rdata = 32'h5555_AAAA;
    tick();
    lsu_if.resp_valid = 1'b0; lsu_if.resp_rdata = '0;
    chk("late_resp_nodone", {31'd0, done}, 32'd0);
    tick();
    chk("late_resp_nodone2", {31'd0, done}, 32'd0);
    issue(2'd0, 32'h1FE0_0020, 32'h0, 4'hF, 1'b0);
    lsu_xact("uload2", 2'd0, 0, 1'b0, 32'h1234_ABCD);
    chk_done("uload2", 32'h1234_ABCD, 1'b0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
